// File: rtl/speed_selector_if.sv
// Key and speed bundle between the board keys and the speed selector.
interface speed_selector_if;
   logic       btn_up_n;
   logic       btn_down_n;
   logic [2:0] speed;
   logic       speed_changed;
   logic       at_max;
   logic       at_min;

   modport master (
      output btn_up_n, btn_down_n,
      input  speed, speed_changed, at_max, at_min
   );

   modport slave (
      input  btn_up_n, btn_down_n,
      output speed, speed_changed, at_max, at_min
   );
endinterface

// File: rtl/speed_selector.sv
// Turns two bouncy active-low keys into a saturating 3-bit speed code with
// press/auto-repeat stepping, status flags and a one-cycle change strobe.
module speed_selector #(
   parameter int DEBOUNCE_CYC      = 1000000,
   parameter int REPEAT_DELAY_CYC  = 25000000,
   parameter int REPEAT_PERIOD_CYC = 10000000,
   parameter int SPEED_MAX         = 7,
   parameter int SPEED_INIT        = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   speed_selector_if.slave         bus
);

   localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
   localparam int TM_MAX = (REPEAT_DELAY_CYC > REPEAT_PERIOD_CYC) ? REPEAT_DELAY_CYC : REPEAT_PERIOD_CYC;
   localparam int TM_W   = $clog2(TM_MAX + 1);
   localparam logic [2:0] MAX3  = 3'(SPEED_MAX);
   localparam logic [2:0] INIT3 = 3'(SPEED_INIT);

   typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

   // Index 0 is the up key, index 1 the down key.
   logic [1:0]      raw;
   logic [1:0]      sync1;
   logic [1:0]      sync2;
   logic [1:0]      deb_lvl;
   logic [DB_W-1:0] db_cnt [2];
   logic [1:0]      pressed;
   logic            both_pressed;

   state_t          state     [2];
   state_t          state_nxt [2];
   logic [TM_W-1:0] timer     [2];
   logic [TM_W-1:0] timer_nxt [2];
   logic [1:0]      step;

   logic [2:0]      speed;
   logic [2:0]      speed_nxt;
   logic            speed_changed;
   logic            at_max;
   logic            at_min;

   assign raw          = {bus.btn_down_n, bus.btn_up_n};
   assign pressed      = ~deb_lvl;
   assign both_pressed = &pressed;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1   <= 2'b11;
         sync2   <= 2'b11;
         deb_lvl <= 2'b11;
         for (int k = 0; k < 2; k++) db_cnt[k] <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         // A level is accepted only after DEBOUNCE_CYC consecutive disagreeing samples.
         for (int k = 0; k < 2; k++) begin
            if (sync2[k] == deb_lvl[k]) begin
               db_cnt[k] <= '0;
            end else if (db_cnt[k] == DB_W'(DEBOUNCE_CYC - 1)) begin
               deb_lvl[k] <= ~deb_lvl[k];
               db_cnt[k]  <= '0;
            end else begin
               db_cnt[k] <= db_cnt[k] + DB_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            state[k] <= IDLE;
            timer[k] <= '0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            state[k] <= state_nxt[k];
            timer[k] <= timer_nxt[k];
         end
      end
   end

   // With both keys held every step is suppressed and timers park at zero,
   // so the survivor resumes from a fresh HOLD once the other is released.
   always_comb begin
      step = 2'b00;
      for (int k = 0; k < 2; k++) begin
         state_nxt[k] = state[k];
         timer_nxt[k] = timer[k];
         case (state[k])
            IDLE: begin
               if (pressed[k]) begin
                  state_nxt[k] = HOLD;
                  timer_nxt[k] = '0;
                  step[k]      = ~both_pressed;
               end
            end
            HOLD: begin
               if (!pressed[k]) begin
                  state_nxt[k] = IDLE;
                  timer_nxt[k] = '0;
               end else if (both_pressed) begin
                  timer_nxt[k] = '0;
               end else if (timer[k] == TM_W'(REPEAT_DELAY_CYC - 1)) begin
                  state_nxt[k] = REPEAT;
                  timer_nxt[k] = '0;
                  step[k]      = 1'b1;
               end else begin
                  timer_nxt[k] = timer[k] + TM_W'(1);
               end
            end
            REPEAT: begin
               if (!pressed[k]) begin
                  state_nxt[k] = IDLE;
                  timer_nxt[k] = '0;
               end else if (both_pressed) begin
                  state_nxt[k] = HOLD;
                  timer_nxt[k] = '0;
               end else if (timer[k] == TM_W'(REPEAT_PERIOD_CYC - 1)) begin
                  timer_nxt[k] = '0;
                  step[k]      = 1'b1;
               end else begin
                  timer_nxt[k] = timer[k] + TM_W'(1);
               end
            end
            default: begin
               state_nxt[k] = IDLE;
               timer_nxt[k] = '0;
            end
         endcase
      end
   end

   always_comb begin
      speed_nxt = speed;
      if (step[0] && !step[1] && speed != MAX3) begin
         speed_nxt = speed + 3'd1;
      end else if (step[1] && !step[0] && speed != 3'd0) begin
         speed_nxt = speed - 3'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         speed         <= INIT3;
         speed_changed <= 1'b0;
         at_max        <= (INIT3 == MAX3);
         at_min        <= (INIT3 == 3'd0);
      end else begin
         speed         <= speed_nxt;
         speed_changed <= (speed_nxt != speed);
         at_max        <= (speed_nxt == MAX3);
         at_min        <= (speed_nxt == 3'd0);
      end
   end

   assign bus.speed         = speed;
   assign bus.speed_changed = speed_changed;
   assign bus.at_max        = at_max;
   assign bus.at_min        = at_min;

endmodule

// File: tb/tb_speed_selector.sv
// Directed bench for speed_selector with short debounce/repeat intervals.
module tb_speed_selector;

   localparam int DEB = 4;
   localparam int DLY = 20;
   localparam int PER = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   speed_selector_if bus();

   speed_selector #(
      .DEBOUNCE_CYC(DEB),
      .REPEAT_DELAY_CYC(DLY),
      .REPEAT_PERIOD_CYC(PER),
      .SPEED_MAX(7),
      .SPEED_INIT(0)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      rst_n          = 1'b0;
      bus.btn_up_n   = 1'b1;
      bus.btn_down_n = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic release_keys(input int n);
      for (int e = 0; e < n; e++) begin
         @(negedge clk);
         bus.btn_up_n   = 1'b1;
         bus.btn_down_n = 1'b1;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      int pulses;
      do_reset();
      #1;
      checks++; if (bus.speed !== 3'd0) begin errors++; $display("[TB] FAIL reset_speed got=%0d exp=0", bus.speed); end
      checks++; if (bus.at_min !== 1'b1) begin errors++; $display("[TB] FAIL reset_at_min got=%b exp=1", bus.at_min); end
      checks++; if (bus.at_max !== 1'b0) begin errors++; $display("[TB] FAIL reset_at_max got=%b exp=0", bus.at_max); end
      pulses = 0;
      for (int e = 0; e < 50; e++) begin
         @(posedge clk); #1;
         if (bus.speed_changed !== 1'b0) pulses++;
      end
      checks++; if (pulses != 0) begin errors++; $display("[TB] FAIL idle_strobe got=%0d exp=0", pulses); end
      checks++; if (bus.speed !== 3'd0) begin errors++; $display("[TB] FAIL idle_speed got=%0d exp=0", bus.speed); end
   endtask

   task automatic test_single_press();
      int edges[$];
      for (int e = 0; e < 31; e++) begin
         @(negedge clk);
         bus.btn_up_n = (e < 10) ? 1'b0 : 1'b1;
         @(posedge clk); #1;
         if (bus.speed_changed === 1'b1) edges.push_back(e);
      end
      checks++; if (edges.size() != 1) begin errors++; $display("[TB] FAIL press_pulses got=%0d exp=1", edges.size()); end
      else begin
         checks++; if (edges[0] != 6) begin errors++; $display("[TB] FAIL press_latency got=%0d exp=6", edges[0]); end
      end
      checks++; if (bus.speed !== 3'd1) begin errors++; $display("[TB] FAIL press_speed got=%0d exp=1", bus.speed); end
   endtask

   task automatic test_bounce();
      int edges[$];
      for (int e = 0; e < 41; e++) begin
         @(negedge clk);
         if (e < 12)      bus.btn_up_n = ((e / 2) % 2 == 0) ? 1'b0 : 1'b1;
         else if (e < 22) bus.btn_up_n = 1'b0;
         else             bus.btn_up_n = 1'b1;
         @(posedge clk); #1;
         if (bus.speed_changed === 1'b1) edges.push_back(e);
      end
      checks++; if (edges.size() != 1) begin errors++; $display("[TB] FAIL bounce_pulses got=%0d exp=1", edges.size()); end
      else begin
         checks++; if (edges[0] != 18) begin errors++; $display("[TB] FAIL bounce_latency got=%0d exp=18", edges[0]); end
      end
      checks++; if (bus.speed !== 3'd2) begin errors++; $display("[TB] FAIL bounce_speed got=%0d exp=2", bus.speed); end
   endtask

   task automatic test_repeat();
      int edges[$];
      int expect_edges[6] = '{6, 26, 34, 42, 50, 58};
      int bad;
      logic [2:0] prev;
      do_reset();
      prev = 3'd0;
      bad  = 0;
      for (int e = 0; e < 60; e++) begin
         @(negedge clk);
         bus.btn_up_n = 1'b0;
         @(posedge clk); #1;
         if (bus.speed_changed === 1'b1) edges.push_back(e);
         if (bus.speed_changed !== (bus.speed != prev)) bad++;
         prev = bus.speed;
      end
      checks++; if (edges.size() != 6) begin errors++; $display("[TB] FAIL repeat_count got=%0d exp=6", edges.size()); end
      else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (edges[i] != expect_edges[i]) begin errors++; $display("[TB] FAIL repeat_edge%0d got=%0d exp=%0d", i, edges[i], expect_edges[i]); end
         end
      end
      checks++; if (bad != 0) begin errors++; $display("[TB] FAIL repeat_strobe_match got=%0d exp=0", bad); end
      checks++; if (bus.speed !== 3'd6) begin errors++; $display("[TB] FAIL repeat_speed got=%0d exp=6", bus.speed); end
      checks++; if (bus.at_max !== 1'b0 || bus.at_min !== 1'b0) begin errors++; $display("[TB] FAIL repeat_flags got=%b%b exp=00", bus.at_max, bus.at_min); end
   endtask

   task automatic test_saturate();
      int edges[$];
      for (int e = 60; e < 90; e++) begin
         @(negedge clk);
         bus.btn_up_n = 1'b0;
         @(posedge clk); #1;
         if (bus.speed_changed === 1'b1) edges.push_back(e);
      end
      checks++; if (edges.size() != 1) begin errors++; $display("[TB] FAIL sat_pulses got=%0d exp=1", edges.size()); end
      else begin
         checks++; if (edges[0] != 66) begin errors++; $display("[TB] FAIL sat_edge got=%0d exp=66", edges[0]); end
      end
      checks++; if (bus.speed !== 3'd7) begin errors++; $display("[TB] FAIL sat_speed got=%0d exp=7", bus.speed); end
      checks++; if (bus.at_max !== 1'b1) begin errors++; $display("[TB] FAIL sat_at_max got=%b exp=1", bus.at_max); end
      release_keys(20);
   endtask

   task automatic test_down_at_min();
      int pulses;
      int moved;
      do_reset();
      pulses = 0;
      moved  = 0;
      for (int e = 0; e < 40; e++) begin
         @(negedge clk);
         bus.btn_down_n = 1'b0;
         @(posedge clk); #1;
         if (bus.speed_changed !== 1'b0) pulses++;
         if (bus.speed !== 3'd0) moved++;
      end
      checks++; if (pulses != 0) begin errors++; $display("[TB] FAIL min_pulses got=%0d exp=0", pulses); end
      checks++; if (moved != 0) begin errors++; $display("[TB] FAIL min_speed_moved got=%0d exp=0", moved); end
      checks++; if (bus.at_min !== 1'b1) begin errors++; $display("[TB] FAIL min_at_min got=%b exp=1", bus.at_min); end
      release_keys(20);
   endtask

   task automatic test_both_keys();
      int edges[$];
      logic [2:0] mid_speed;
      do_reset();
      mid_speed = 3'd0;
      for (int e = 0; e < 71; e++) begin
         @(negedge clk);
         bus.btn_up_n   = (e < 42) ? 1'b0 : 1'b1;
         bus.btn_down_n = (e >= 2) ? 1'b0 : 1'b1;
         @(posedge clk); #1;
         if (bus.speed_changed === 1'b1) edges.push_back(e);
         if (e == 66) mid_speed = bus.speed;
      end
      checks++; if (edges.size() != 2) begin errors++; $display("[TB] FAIL both_pulses got=%0d exp=2", edges.size()); end
      else begin
         checks++; if (edges[0] != 6) begin errors++; $display("[TB] FAIL both_up_edge got=%0d exp=6", edges[0]); end
         checks++; if (edges[1] != 67) begin errors++; $display("[TB] FAIL both_down_edge got=%0d exp=67", edges[1]); end
      end
      checks++; if (mid_speed !== 3'd1) begin errors++; $display("[TB] FAIL both_held_speed got=%0d exp=1", mid_speed); end
      checks++; if (bus.speed !== 3'd0) begin errors++; $display("[TB] FAIL both_final_speed got=%0d exp=0", bus.speed); end
      release_keys(20);
   endtask

   task automatic test_async_reset();
      int edges[$];
      do_reset();
      for (int e = 0; e < 36; e++) begin
         @(negedge clk);
         bus.btn_up_n = 1'b0;
         @(posedge clk); #1;
      end
      checks++; if (bus.speed !== 3'd3) begin errors++; $display("[TB] FAIL pre_reset_speed got=%0d exp=3", bus.speed); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.speed !== 3'd0) begin errors++; $display("[TB] FAIL async_speed got=%0d exp=0", bus.speed); end
      checks++; if (bus.at_min !== 1'b1) begin errors++; $display("[TB] FAIL async_at_min got=%b exp=1", bus.at_min); end
      // The key stays held through reset and must be debounced afresh.
      for (int e = 0; e < 12; e++) begin
         @(negedge clk);
         if (e == 0) rst_n = 1'b1;
         bus.btn_up_n = 1'b0;
         @(posedge clk); #1;
         if (bus.speed_changed === 1'b1) edges.push_back(e);
      end
      checks++; if (edges.size() != 1) begin errors++; $display("[TB] FAIL rehold_pulses got=%0d exp=1", edges.size()); end
      else begin
         checks++; if (edges[0] != 6) begin errors++; $display("[TB] FAIL rehold_edge got=%0d exp=6", edges[0]); end
      end
      release_keys(10);
   endtask

   initial begin
      bus.btn_up_n   = 1'b1;
      bus.btn_down_n = 1'b1;
      test_reset();
      test_single_press();
      test_bounce();
      test_repeat();
      test_saturate();
      test_down_at_min();
      test_both_keys();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
